// File: rtl/main_mem_if.sv
// Port bundle for main_mem: one synchronous command port plus registered read data and busy.
interface main_mem_if;
  // Handshake: a command is taken on a rising edge with enable=1 while busy=0; while busy=1 only
  // enable (freeze/resume) and data_in (write beats) matter, and data_out is valid after each read beat.
  logic [0:31] addr;
  logic [0:31] data_in;
  logic [0:31] data_out;
  logic [0:1]  acc_size;
  logic        wren;
  logic        busy;
  logic        enable;

  modport master (output addr, data_in, acc_size, wren, enable, input data_out, busy);
  modport slave  (input addr, data_in, acc_size, wren, enable, output data_out, busy);
endinterface

// File: rtl/main_mem.sv
// Word-organized main memory with single-word and 4/8/16-word bursts on one synchronous port.
// Optional MAIN_MEM_BOUNDS_CHECK_EN: out-of-range beats are suppressed instead of wrapping.
module main_mem #(
  parameter logic [31:0] BASE_ADDR   = 32'h8002_0000,
  parameter int          DEPTH_WORDS = 262144
) (
  input  logic       clock,
  input  logic       reset,
  main_mem_if.slave  bus,
  output logic       dbg_state
);
  localparam int          IW      = $clog2(DEPTH_WORDS);
  localparam logic [31:0] DEPTH32 = 32'(DEPTH_WORDS);

  typedef enum logic {IDLE = 1'b0, BURST = 1'b1} state_t;

  state_t      state;
  logic [31:0] base_word;
  logic [3:0]  beat;
  logic [3:0]  last_beat;
  logic        dir_wr;

  logic [0:31] mem [DEPTH_WORDS];

  logic [31:0] off;
  logic [31:0] cmd_word;
  logic [31:0] acc_word;
  logic [IW-1:0] mem_idx;
  logic        in_range;
  logic        do_wr;
  logic [3:0]  cmd_last;

  always_comb begin
    off      = bus.addr - BASE_ADDR;
    // Signed word offset so addresses below the base are seen as negative indices.
    cmd_word = 32'($signed(off) >>> 2);
    acc_word = (state == IDLE) ? cmd_word : base_word + {28'b0, beat};
    mem_idx  = IW'(acc_word % DEPTH32);
`ifdef MAIN_MEM_BOUNDS_CHECK_EN
    in_range = !acc_word[31] && (acc_word < DEPTH32);
`else
    in_range = 1'b1;
`endif
    do_wr    = !reset && bus.enable && in_range &&
               ((state == IDLE) ? bus.wren : dir_wr);
    case (bus.acc_size)
      2'b01:   cmd_last = 4'd3;
      2'b10:   cmd_last = 4'd7;
      2'b11:   cmd_last = 4'd15;
      default: cmd_last = 4'd0;
    endcase
  end

  // Contents survive reset; only the control path is cleared.
  always_ff @(posedge clock) begin
    if (do_wr) mem[mem_idx] <= bus.data_in;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      bus.data_out <= '0;
      bus.busy  <= 1'b0;
      base_word <= '0;
      beat      <= '0;
      last_beat <= '0;
      dir_wr    <= 1'b0;
    end else if (bus.enable) begin
      case (state)
        IDLE: begin
          if (!bus.wren) bus.data_out <= in_range ? mem[mem_idx] : '0;
          if (cmd_last != 4'd0) begin
            state     <= BURST;
            bus.busy  <= 1'b1;
            base_word <= cmd_word;
            dir_wr    <= bus.wren;
            beat      <= 4'd1;
            last_beat <= cmd_last;
          end
        end
        BURST: begin
          if (!dir_wr) bus.data_out <= in_range ? mem[mem_idx] : '0;
          if (beat == last_beat) begin
            state    <= IDLE;
            bus.busy <= 1'b0;
          end else begin
            beat <= beat + 4'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign dbg_state = state;
endmodule

// File: tb/tb_main_mem.sv
// Directed bench for main_mem: a word model feeds an expected-read queue checked every beat.
module tb_main_mem;
  localparam logic [31:0] BASE  = 32'h8002_0000;
  localparam int          DEPTH = 262144;

  logic clock;
  logic reset;
  logic dbg_state;
  main_mem_if bus ();

  main_mem #(.BASE_ADDR(BASE), .DEPTH_WORDS(DEPTH)) dut (
    .clock     (clock),
    .reset     (reset),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];
  logic [31:0] model [int];
  logic [31:0] last_out = '0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  function automatic int word_of(input logic [31:0] a, input int k);
    logic [31:0] off;
    off = a - BASE;
    return ($signed(off) >>> 2) + k;
  endfunction

  function automatic bit ok_word(input int w);
`ifdef MAIN_MEM_BOUNDS_CHECK_EN
    return (w >= 0) && (w < DEPTH);
`else
    return 1'b1;
`endif
  endfunction

  function automatic logic [31:0] model_rd(input logic [31:0] a, input int k);
    int w;
    w = word_of(a, k);
    if (!ok_word(w)) return 32'h0;
    if (!model.exists(w & (DEPTH - 1))) return 32'hDEAD_BEEF;
    return model[w & (DEPTH - 1)];
  endfunction

  function automatic int beats(input logic [1:0] sz);
    case (sz)
      2'b01:   return 4;
      2'b10:   return 8;
      2'b11:   return 16;
      default: return 1;
    endcase
  endfunction

  // One command plus its burst beats; optional enable gap, mid-burst reset, and junk commands while busy.
  task automatic run_burst(input bit wr, input logic [31:0] a, input logic [1:0] sz,
                           input logic [31:0] seed, input int gap_at, input int gap_len,
                           input int rst_at, input bit junk);
    int n;
    int k;
    int gaps;
    logic [31:0] d;
    logic [31:0] e;
    n = beats(sz);
    k = 0;
    gaps = 0;
    while (k < n) begin
      if (k == gap_at && gaps < gap_len) begin
        bus.enable  = 1'b0;
        bus.wren    = 1'($urandom_range(0, 1));
        bus.addr    = $urandom;
        bus.data_in = $urandom;
        @(posedge clock); #1;
        check("gap_busy", {31'b0, bus.busy}, {31'b0, (k > 0)});
        check("gap_hold", bus.data_out, last_out);
        gaps++;
        continue;
      end
      bus.enable = 1'b1;
      if (k == 0) begin
        bus.addr = a;
        bus.acc_size = sz;
        bus.wren = wr;
      end else if (junk) begin
        bus.addr = $urandom;
        bus.wren = 1'b1;
        bus.acc_size = 2'($urandom_range(0, 3));
      end
      d = wr ? seed + 32'(k) * 32'h0101_0101 : $urandom;
      bus.data_in = d;
      if (k == rst_at) reset = 1'b1;
      if (!wr && k != rst_at) exp_q.push_back(model_rd(a, k));
      @(posedge clock); #1;
      if (k == rst_at) begin
        reset = 1'b0;
        bus.enable = 1'b0;
        bus.wren = 1'b0;
        check("rst_busy", {31'b0, bus.busy}, 32'h0);
        check("rst_data", bus.data_out, 32'h0);
        last_out = '0;
        return;
      end
      if (wr) begin
        if (ok_word(word_of(a, k))) model[word_of(a, k) & (DEPTH - 1)] = d;
      end else if (exp_q.size() == 0) begin
        check("queue_empty", 32'h1, 32'h0);
      end else begin
        e = exp_q.pop_front();
        check("rd_data", bus.data_out, e);
        last_out = e;
      end
      check("busy", {31'b0, bus.busy}, {31'b0, (k < n - 1)});
      k++;
    end
    bus.enable = 1'b0;
    bus.wren = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    bus.enable = 1'b0;
    bus.wren = 1'b0;
    bus.addr = '0;
    bus.data_in = '0;
    bus.acc_size = 2'b00;
    repeat (3) @(posedge clock);
    #1;
    check("reset_data", bus.data_out, 32'h0);
    check("reset_busy", {31'b0, bus.busy}, 32'h0);
    check("reset_state", {31'b0, dbg_state}, 32'h0);
    reset = 1'b0;
    @(posedge clock); #1;

    run_burst(1'b1, BASE, 2'b00, 32'h27BD_FFD0, -1, 0, -1, 1'b0);
    run_burst(1'b0, BASE, 2'b00, 32'h0, -1, 0, -1, 1'b0);
    check("single_value", bus.data_out, 32'h27BD_FFD0);

    run_burst(1'b1, BASE + 32'h04, 2'b01, 32'hA000_0000, -1, 0, -1, 1'b0);
    run_burst(1'b0, BASE + 32'h04, 2'b01, 32'h0, -1, 0, -1, 1'b0);

    run_burst(1'b1, BASE + 32'h14, 2'b10, 32'hB000_0010, -1, 0, -1, 1'b0);
    run_burst(1'b1, BASE + 32'h34, 2'b11, 32'hC000_0020, -1, 0, -1, 1'b0);
    run_burst(1'b0, BASE + 32'h14, 2'b10, 32'h0, -1, 0, -1, 1'b0);
    run_burst(1'b0, BASE + 32'h34, 2'b11, 32'h0, -1, 0, -1, 1'b0);

    run_burst(1'b0, BASE + 32'h34, 2'b11, 32'h0, -1, 0, -1, 1'b1);
    run_burst(1'b0, BASE + 32'h34, 2'b11, 32'h0, -1, 0, -1, 1'b0);

    run_burst(1'b1, BASE + 32'h200, 2'b10, 32'h1111_0000, -1, 0, -1, 1'b0);
    run_burst(1'b1, BASE + 32'h200, 2'b10, 32'h2222_0000, -1, 0, 2, 1'b0);
    @(posedge clock); #1;
    run_burst(1'b0, BASE + 32'h200, 2'b10, 32'h0, -1, 0, -1, 1'b0);
    check("rst_beat1", bus.data_out, 32'h1111_0000 + 32'd7 * 32'h0101_0101);

    run_burst(1'b1, BASE + 32'h300, 2'b11, 32'h3300_0000, 5, 3, -1, 1'b0);
    run_burst(1'b0, BASE + 32'h300, 2'b11, 32'h0, 7, 3, -1, 1'b0);

    run_burst(1'b1, BASE + 32'(4 * DEPTH), 2'b00, 32'h5A5A_0001, -1, 0, -1, 1'b0);
    run_burst(1'b0, BASE, 2'b00, 32'h0, -1, 0, -1, 1'b0);
`ifdef MAIN_MEM_BOUNDS_CHECK_EN
    run_burst(1'b0, BASE + 32'h04, 2'b00, 32'h0, -1, 0, -1, 1'b0);
    run_burst(1'b0, BASE - 32'h04, 2'b00, 32'h0, -1, 0, -1, 1'b0);
    check("below_base", bus.data_out, 32'h0);
`else
    check("wrap_alias", bus.data_out, 32'h5A5A_0001);
`endif

    @(posedge clock); #1;
    check("end_busy", {31'b0, bus.busy}, 32'h0);
    check("end_queue", 32'(exp_q.size()), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
